// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB first,
// taking WIDTH clocks per operation, with carry-out and signed-overflow flags.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;

    // Shared full-adder cell; the new sum bit enters the result from the MSB side.
    always_comb begin
        w_s        = (r_a[0] ^ r_b[0]) ^ r_c;
        w_c        = (r_a[0] & r_b[0]) | (r_b[0] & r_c) | (r_c & r_a[0]);
        w_res_next = r_res >> 1;
        w_res_next[WIDTH-1] = w_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // On the MSB step r_c is the carry into the MSB, w_c the carry out.
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_ovf   <= r_c ^ w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive bench for serial_addsub at WIDTH = 8, 3 and 1.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start3 = 1'b0, sub3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    logic       start1 = 1'b0, sub1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       busy1, done1, cout1, ovf1;
    logic       sum1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_addsub #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );
    serial_addsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {cout, ovf, sum} of a +/- b on w bits.
    function automatic logic [65:0] refm(input int w, input logic s,
                                         input logic [63:0] ia, input logic [63:0] ib);
        logic [64:0] mask, aa, bb, full;
        logic        c, o;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ia} & mask;
        bb   = (s ? ~{1'b0, ib} : {1'b0, ib}) & mask;
        full = aa + bb + {64'd0, s};
        c    = full[w];
        o    = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return {c, o, full[63:0] & mask[63:0]};
    endfunction

    task automatic set_in(input int w, input logic st, input logic s,
                          input logic [63:0] ia, input logic [63:0] ib);
        case (w)
            1:       begin start1 = st; sub1 = s; a1 = ia[0];   b1 = ib[0];   end
            3:       begin start3 = st; sub3 = s; a3 = ia[2:0]; b3 = ib[2:0]; end
            default: begin start8 = st; sub8 = s; a8 = ia[7:0]; b8 = ib[7:0]; end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            1:       return busy1;
            3:       return busy3;
            default: return busy8;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1:       return done1;
            3:       return done3;
            default: return done8;
        endcase
    endfunction

    function automatic logic [65:0] get_res(input int w);
        case (w)
            1:       return {cout1, ovf1, 63'd0, sum1};
            3:       return {cout3, ovf3, 61'd0, sum3};
            default: return {cout8, ovf8, 56'd0, sum8};
        endcase
    endfunction

    // One operation with operands scrambled right after acceptance.
    task automatic do_op(input int w, input logic s, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] es, input logic ec, input logic eo, input string tag);
        int   nb;
        logic seen;
        logic [65:0] r;
        @(negedge clk);
        set_in(w, 1'b1, s, ia, ib);
        @(posedge clk); #1;
        set_in(w, 1'b0, ~s, ~ia, ib + 64'd3);
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (get_done(w)) begin
                seen = 1'b1;
                break;
            end
            if (get_busy(w)) nb++;
            @(posedge clk); #1;
        end
        r = get_res(w);
        check($sformatf("%s done_seen", tag), {63'd0, seen}, 64'd1);
        check($sformatf("%s busy_cycles", tag), 64'(nb), 64'(w));
        check($sformatf("%s busy_at_done", tag), {63'd0, get_busy(w)}, 64'd0);
        check($sformatf("%s sum", tag), r[63:0], es);
        check($sformatf("%s cout", tag), {63'd0, r[65]}, {63'd0, ec});
        check($sformatf("%s ovf", tag), {63'd0, r[64]}, {63'd0, eo});
        @(posedge clk); #1;
        r = get_res(w);
        check($sformatf("%s done_width", tag), {63'd0, get_done(w)}, 64'd0);
        check($sformatf("%s sum_hold", tag), r[63:0], es);
    endtask

    initial begin
        logic [65:0] e;
        logic [7:0]  ha [0:31];
        logic [7:0]  hb [0:31];
        logic        hs [0:31];
        int          nd;

        // Reset state, with start held high while in reset
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
        #1;
        check("rst busy", {63'd0, busy8}, 64'd0);
        check("rst done", {63'd0, done8}, 64'd0);
        check("rst sum", {56'd0, sum8}, 64'd0);
        check("rst flags", {62'd0, cout8, ovf8}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst start_ignored", {63'd0, busy8}, 64'd0);
        @(negedge clk);
        start8 = 1'b0;
        rst    = 1'b0;

        // Directed WIDTH=8 vectors
        do_op(8, 1'b0, 64'h3C, 64'h5A, 64'h96, 1'b0, 1'b1, "add_3C_5A");
        do_op(8, 1'b0, 64'hFF, 64'h01, 64'h00, 1'b1, 1'b0, "add_FF_01");
        do_op(8, 1'b1, 64'h10, 64'h20, 64'hF0, 1'b0, 1'b0, "sub_10_20");
        do_op(8, 1'b1, 64'h80, 64'h01, 64'h7F, 1'b1, 1'b1, "sub_80_01");
        do_op(8, 1'b0, 64'h7F, 64'h01, 64'h80, 1'b0, 1'b1, "add_7F_01");
        do_op(8, 1'b1, 64'h05, 64'h05, 64'h00, 1'b1, 1'b0, "sub_05_05");

        // start held high with operands changing every cycle: accepts at j = 0, 10, 20
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            ha[j] = 8'(j * 37 + 5);
            hb[j] = 8'(j * 11 + 3);
            hs[j] = j[0];
            start8 = 1'b1; a8 = ha[j]; b8 = hb[j]; sub8 = hs[j];
            @(posedge clk); #1;
            check($sformatf("hold busy j%0d", j), {63'd0, busy8}, {63'd0, ((j % 10) < 8)});
            check($sformatf("hold done j%0d", j), {63'd0, done8}, {63'd0, ((j % 10) == 8)});
            if ((j % 10) == 8) begin
                e = refm(8, hs[j-8], {56'd0, ha[j-8]}, {56'd0, hb[j-8]});
                check($sformatf("hold res j%0d", j), {62'd0, cout8, ovf8, 56'd0, sum8}, e);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset after the third RUN edge
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("abort pre_busy", {63'd0, busy8}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {63'd0, busy8}, 64'd0);
        check("abort sum", {56'd0, sum8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        check("abort no_done", 64'(nd), 64'd0);
        do_op(8, 1'b0, 64'h01, 64'h01, 64'h02, 1'b0, 1'b0, "after_abort");

        // Exhaustive at WIDTH=3 and WIDTH=1
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    e = refm(3, s[0], 64'(x), 64'(y));
                    do_op(3, s[0], 64'(x), 64'(y), e[63:0], e[65], e[64],
                          $sformatf("w3 s%0d a%0d b%0d", s, x, y));
                end
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 2; x++)
                for (int y = 0; y < 2; y++) begin
                    e = refm(1, s[0], 64'(x), 64'(y));
                    do_op(1, s[0], 64'(x), 64'(y), e[63:0], e[65], e[64],
                          $sformatf("w1 s%0d a%0d b%0d", s, x, y));
                end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
